// File: rtl/rom_stream_reader_pkg.sv
// Shared types and default widths for the lookup ROM and its stream reader.
package rom_stream_reader_pkg;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 4;
  localparam int DEF_DEPTH  = 8;
  localparam int DEF_LEN_W  = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } rd_state_e;
endpackage

// File: rtl/rom_stream_reader_if.sv
// Command, ROM read port and output stream of the ROM stream reader.
interface rom_stream_reader_if
  import rom_stream_reader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W
);
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [LEN_W-1:0]  start_len;
  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    input  start, start_addr, start_len, rom_data, out_ready,
    output rom_en, rom_addr, out_valid, out_data, out_last, busy, done, err
  );

  modport slave (
    output start, start_addr, start_len, rom_data, out_ready,
    input  rom_en, rom_addr, out_valid, out_data, out_last, busy, done, err
  );
endinterface

// File: rtl/rom_stream_fifo2.sv
// Two-entry FIFO for captured ROM words; simultaneous push and pop are both honoured.
module rom_stream_fifo2 #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic [1:0]   count,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] mem_q [2];
  logic         wr_q;
  logic         rd_q;
  logic [1:0]   count_q;
  logic         do_push;
  logic         do_pop;

  assign empty   = (count_q == 2'd0);
  assign full    = (count_q == 2'd2);
  assign count   = count_q;
  assign rdata   = mem_q[rd_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= wdata;
        wr_q        <= ~wr_q;
      end
      if (do_pop) begin
        rd_q <= ~rd_q;
      end
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end
endmodule

// File: rtl/rom_stream_reader.sv
// Reads a wrapped address range from the synchronous lookup ROM and streams the words out.
module rom_stream_reader
  import rom_stream_reader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int LEN_W  = DEF_LEN_W
) (
  input logic                 clk,
  input logic                 rst_n,
  rom_stream_reader_if.master bus
);
  // state    | meaning
  // ST_IDLE  | waiting for a start command
  // ST_RUN   | issuing ROM reads while issue count remains
  // ST_FLUSH | all reads issued, draining until the last word is popped

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

  rd_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  remain_q;
  logic              infl_q;
  logic              infl_last_q;
  logic              done_q;
  logic              err_q;
  logic              issue;
  logic              cmd_go;
  logic              cmd_bad_addr;
  logic              cmd_empty;
  logic              pop;
  logic              push;
  logic              fifo_full;
  logic              fifo_empty;
  logic [1:0]        fifo_count;
  logic              head_last;
  logic [DATA_W-1:0] head_data;
  logic [2:0]        load;

  assign cmd_bad_addr = ({1'b0, bus.start_addr} >= (ADDR_W+1)'(DEPTH));
  assign cmd_empty    = (bus.start_len == '0);
  assign pop          = ~fifo_empty & bus.out_ready;
  assign push         = infl_q & (~fifo_full | pop);
  // words already held or in flight, net of this cycle's pop; keeps the FIFO from overflowing
  assign load         = {1'b0, fifo_count} + {2'b0, infl_q} - {2'b0, pop};

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    cmd_go  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start && !cmd_bad_addr && !cmd_empty) begin
          cmd_go  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        issue = (remain_q != '0) && (load < 3'd2);
        if (issue && (remain_q == LEN_W'(1))) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (pop && head_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      remain_q    <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (cmd_go) begin
        addr_q   <= bus.start_addr;
        remain_q <= bus.start_len;
      end else if (issue) begin
        addr_q   <= (addr_q == ADDR_LAST) ? '0 : addr_q + 1'b1;
        remain_q <= remain_q - 1'b1;
      end
      infl_q      <= issue;
      infl_last_q <= issue && (remain_q == LEN_W'(1));
      done_q      <= ((state_q == ST_FLUSH) && pop && head_last) ||
                     ((state_q == ST_IDLE) && bus.start && !cmd_bad_addr && cmd_empty);
      err_q       <= (state_q == ST_IDLE) && bus.start && cmd_bad_addr;
    end
  end

  rom_stream_fifo2 #(.W(DATA_W + 1)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({infl_last_q, bus.rom_data}),
    .pop   (pop),
    .rdata ({head_last, head_data}),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.rom_en    = issue;
  assign bus.rom_addr  = addr_q;
  assign bus.out_valid = ~fifo_empty;
  assign bus.out_data  = head_data;
  assign bus.out_last  = head_last;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = done_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_rom_stream_reader.sv
// Scoreboard bench for rom_stream_reader: directed scenarios plus randomized commands and backpressure.
module tb_rom_stream_reader;
  import rom_stream_reader_pkg::*;

  localparam int AW  = DEF_ADDR_W;
  localparam int DW  = DEF_DATA_W;
  localparam int DEP = DEF_DEPTH;
  localparam int LW  = DEF_LEN_W;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rom_stream_reader_if #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) bus ();

  rom_stream_reader #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP), .LEN_W(LW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [DW-1:0] rom_tbl [DEP];
  always @(posedge clk) if (bus.rom_en) bus.rom_data <= rom_tbl[bus.rom_addr[2:0]];

  logic [AW-1:0] exp_addr [$];
  logic [DW:0]   exp_word [$];
  int n_checks = 0, n_pass = 0;
  int issued = 0, accepted = 0, done_seen = 0, err_seen = 0, exp_done = 0, exp_err = 0;
  bit hold_v = 0, rand_rdy = 0, popv;
  logic [DW:0] hold_w, cur_w, want_w;
  logic [AW-1:0] want_a;

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      issued = 0; accepted = 0; hold_v = 0;
    end else begin
      cur_w = {bus.out_last, bus.out_data};
      popv  = bus.out_valid && bus.out_ready;
      if (hold_v)
        check(bus.out_valid && cur_w == hold_w, "hold_stable", {bus.out_valid, cur_w}, {1'b1, hold_w});
      if (popv) begin
        check(exp_word.size() != 0, "word_expected", exp_word.size(), 1);
        if (exp_word.size() != 0) begin
          want_w = exp_word.pop_front();
          check(cur_w == want_w, "word", cur_w, want_w);
        end
      end
      if (bus.rom_en) begin
        check((issued - accepted - int'(popv)) < 2, "issue_limit", issued - accepted - int'(popv), 1);
        check(exp_addr.size() != 0, "addr_expected", exp_addr.size(), 1);
        if (exp_addr.size() != 0) begin
          want_a = exp_addr.pop_front();
          check(bus.rom_addr == want_a, "rom_addr", bus.rom_addr, want_a);
        end
      end
      issued   += int'(bus.rom_en);
      accepted += int'(popv);
      hold_v = bus.out_valid && !bus.out_ready;
      hold_w = cur_w;
      if (bus.done) done_seen++;
      if (bus.err)  err_seen++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic issue_cmd(input int addr, input int len);
    int a;
    bus.start      = 1'b1;
    bus.start_addr = AW'(addr);
    bus.start_len  = LW'(len);
    if (addr >= DEP) exp_err++;
    else begin
      exp_done++;
      for (int i = 0; i < len; i++) begin
        a = (addr + i) % DEP;
        exp_addr.push_back(AW'(a));
        exp_word.push_back({(i == len - 1), rom_tbl[a]});
      end
    end
    tick();
    bus.start = 1'b0;
    if (addr >= DEP)
      check(bus.err && !bus.busy, "err_pulse", {bus.err, bus.busy}, 2);
    else if (len == 0)
      check(bus.done && !bus.busy && !bus.rom_en, "empty_done", {bus.done, bus.busy, bus.rom_en}, 4);
    else
      check(bus.busy, "busy_after_start", bus.busy, 1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (bus.busy && n < 3000) begin
      tick();
      n++;
    end
    check(!bus.busy, {name, "_timeout"}, n, 3000);
    check(bus.done, {name, "_done"}, bus.done, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int db;
    for (int i = 0; i < DEP; i++) rom_tbl[i] = DW'((2 * i) % 16);
    bus.start = 0; bus.start_addr = '0; bus.start_len = '0;
    bus.out_ready = 0; bus.rom_data = '0;
    rst_n = 0;
    #1;
    check({bus.out_valid, bus.busy, bus.rom_en, bus.done, bus.err, bus.out_data, bus.out_last} == '0,
          "reset_outputs", {bus.out_valid, bus.busy, bus.rom_en, bus.done, bus.err}, 0);
    repeat (3) tick();
    rst_n = 1;
    tick();
    check({bus.out_valid, bus.busy, bus.rom_en, bus.done, bus.err} == '0, "after_reset",
          {bus.out_valid, bus.busy, bus.rom_en, bus.done, bus.err}, 0);

    // basic 8-word read with exact cycle timing
    bus.out_ready = 1;
    issue_cmd(0, 8);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      check(bus.rom_en == (c <= 8), $sformatf("t1_rom_en_c%0d", c), bus.rom_en, c <= 8);
      check(bus.out_valid == (c >= 3 && c <= 10), $sformatf("t1_valid_c%0d", c), bus.out_valid, c >= 3 && c <= 10);
      check(bus.done == (c == 11), $sformatf("t1_done_c%0d", c), bus.done, c == 11);
      check(bus.busy == (c <= 10), $sformatf("t1_busy_c%0d", c), bus.busy, c <= 10);
      tick();
    end

    issue_cmd(6, 4);
    wait_idle("wrap");
    tick();

    // consumer stalls in cycles 4..7
    issue_cmd(0, 5);
    for (int c = 1; c <= 7; c++) begin
      bus.out_ready = !(c >= 4);
      tick();
    end
    bus.out_ready = 1;
    wait_idle("backpressure");
    tick();

    issue_cmd(9, 5);
    repeat (3) tick();
    issue_cmd(3, 0);
    repeat (3) tick();

    // starts while busy are ignored, valid or not
    issue_cmd(2, 3);
    bus.start = 1; bus.start_addr = AW'(4); bus.start_len = LW'(7);
    tick();
    bus.start_addr = AW'(12);
    tick();
    bus.start = 0;
    wait_idle("busy_start");
    tick();

    // reset with two words buffered and consumer stalled
    bus.out_ready = 0;
    issue_cmd(0, 8);
    repeat (5) tick();
    #2 rst_n = 0;
    #1;
    check({bus.out_valid, bus.busy, bus.rom_en} == 3'b000, "reset_midrun",
          {bus.out_valid, bus.busy, bus.rom_en}, 0);
    exp_addr.delete();
    exp_word.delete();
    exp_done--;
    tick(); tick();
    rst_n = 1;
    db = done_seen;
    repeat (4) tick();
    check(done_seen == db && !bus.busy, "no_done_after_reset", done_seen - db, 0);
    bus.out_ready = 1;
    issue_cmd(5, 6);
    wait_idle("after_reset_cmd");
    tick();

    rand_rdy = 1;
    for (int k = 0; k < 30; k++) begin
      int a, l;
      a = $urandom_range(0, 9);
      l = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 20);
      issue_cmd(a, l);
      if (a < DEP && l > 0) wait_idle($sformatf("rand%0d", k));
      repeat ($urandom_range(0, 2)) tick();
    end
    rand_rdy = 0;
    bus.out_ready = 1;
    repeat (5) tick();

    check(exp_word.size() == 0, "words_left", exp_word.size(), 0);
    check(exp_addr.size() == 0, "addrs_left", exp_addr.size(), 0);
    check(done_seen == exp_done, "done_count", done_seen, exp_done);
    check(err_seen == exp_err, "err_count", err_seen, exp_err);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/rom_stream_reader.md
Name: rom_stream_reader

Overview:
- Read-side master for the team's synchronous lookup ROM: issues ROM addresses and captures the returned words.
- Emits the words as a valid/ready stream with a last flag.
- Started by a one-cycle command carrying a base address and a word count. Addresses wrap modulo DEPTH.
- Sits between a control unit and any consumer that needs table contents streamed out in order.

Parameters:
- ADDR_W, 8, width of ROM address and start address
- DATA_W, 4, ROM word width
- DEPTH, 8, number of valid ROM entries; address wraps from DEPTH-1 to 0
- LEN_W, 9, width of word-count field (max count 2^LEN_W - 1)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle command pulse; honoured only when busy=0
- start_addr  in  ADDR_W  first ROM address to read
- start_len  in  LEN_W  number of words to stream
- rom_en  out  1  read strobe to ROM
- rom_addr  out  ADDR_W  ROM address, meaningful when rom_en=1
- rom_data  in  DATA_W  ROM read data, valid exactly one cycle after rom_en
- out_valid  out  1  stream word available
- out_ready  in  1  consumer accepts word
- out_data  out  DATA_W  stream word
- out_last  out  1  marks final word of the command
- busy  out  1  command in progress
- done  out  1  one-cycle pulse at command completion
- err  out  1  one-cycle pulse when a command is rejected

Behaviour:
- Reset: all outputs 0. FSM returns to IDLE. Buffer is emptied, in-flight read is discarded, and all counters are cleared. A reset mid-command abandons the command with no done pulse.
- FSM states: IDLE, RUN, FLUSH.
- IDLE, start=1 with start_addr >= DEPTH: err=1 next cycle, stay IDLE.
- IDLE, start=1 with start_len=0: done=1 next cycle, no reads, stay IDLE.
- IDLE, start=1 otherwise: latch the address and remaining-issue count = start_len. Go to RUN; busy=1 from the next cycle.
- start while busy=1: ignored with no effect. err is not raised.
- RUN issue rule: rom_en=1 when remaining-issue count > 0 AND (buffer occupancy + in-flight - pop this cycle) < 2.
  - "in-flight" means rom_en was high in the previous cycle.
  - On each issue: the address increments and wraps (DEPTH-1 -> 0), and the remaining-issue count decrements.
- Read latency: rom_en in cycle T, rom_data sampled at the end of T+1, word visible on out_data/out_valid in T+2.
- First word: start sampled in cycle 0, rom_en in cycle 1, out_valid in cycle 3.
- Throughput: sustained 1 word/cycle when out_ready is held high.
- Buffer: 2-entry FIFO holding captured words with a per-entry last bit. It never overflows, which the issue rule guarantees.
  - out_valid = FIFO non-empty; out_data/out_last come from the head entry.
  - Pop occurs on out_valid & out_ready.
  - Push and pop in the same cycle are both honoured.
- out_valid, out_data and out_last are held stable while out_valid=1 and out_ready=0.
- out_last is set on the word from the final issued address.
- When the remaining-issue count reaches 0: RUN -> FLUSH.
- FLUSH: when the last word is popped, done=1 the following cycle, busy=0 that same cycle, and the FSM returns to IDLE. The earliest a new start is accepted is the cycle done is high.
- Counts above DEPTH re-read the wrapped addresses. Data order always follows address order.

Decomposition:
- Shared package holds the FSM state typedef (IDLE/RUN/FLUSH) and default width constants ADDR_W/DATA_W/LEN_W/DEPTH used by the ROM and this reader.
- One sub-module: rom_stream_fifo2, the 2-entry FIFO with {last, data} entries, exposing count, push, pop and full/empty.

Test Plan:
- ROM contents 2*i mod 16. start_addr=0, start_len=8, out_ready=1: rom_en cycles 1-8, out_data 0,2,4,6,8,10,12,14 on cycles 3-10, out_last on 14, done in cycle 11.
- Wrap: start_addr=6, start_len=4 -> 12,14,0,2; out_last on 2; rom_addr sequence 6,7,0,1.
- Backpressure: start_addr=0, start_len=5, out_ready low cycles 4-7: data held stable, rom_en never high with buffer full, no word lost or duplicated; sequence 0,2,4,6,8.
- Rejects: start_addr=9 -> err pulse, busy stays 0. start_len=0 -> done pulse, no rom_en, no out_valid.
- start pulsed during a busy start_len=3 run: ignored, exactly 3 words delivered, single done.
- rst_n driven low mid-run with the buffer holding 2 words: out_valid, busy and rom_en go 0 immediately. No done after release. A new command after release streams correctly from its start_addr.
